// File: rtl/alu_pkg.sv
// Shared constants for the accumulator-processor ALU: operand width and op codes.
// Pure declarations; no logic, no latency, no flow control.
// Imported by alu_core and the alu top level.
package alu_pkg;

    localparam int WIDTH_DEF = 16;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_AND   = 3'd2;
    localparam logic [2:0] OP_OR    = 3'd3;
    localparam logic [2:0] OP_XOR   = 3'd4;
    localparam logic [2:0] OP_SLL   = 3'd5;
    localparam logic [2:0] OP_SRA   = 3'd6;
    localparam logic [2:0] OP_PASSB = 3'd7;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result mux, equality flag and signed <= flag.
// Latency: zero cycles (pure combinational).
// No backpressure; outputs follow inputs continuously.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             ble,
    output logic             eq
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0] shamt;

    // Only the low bits of B steer the shifter; upper bits are ignored.
    assign shamt = b[SHW-1:0];

    always_comb begin
        result = b;
        case (op)
            OP_ADD:   result = a + b;
            OP_SUB:   result = a - b;
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_XOR:   result = a ^ b;
            OP_SLL:   result = a << shamt;
            OP_SRA:   result = $signed(a) >>> shamt;
            OP_PASSB: result = b;
            default:  result = b;
        endcase
    end

    // Direct signed compare, so A - B overflow cannot corrupt the flag.
    assign ble = ($signed(a) <= $signed(b));
    assign eq  = (a == b);

endmodule

// File: rtl/alu.sv
// 16-bit ALU with registered result and branch flags (eq, signed <=).
// Latency: one clock; outputs reflect inputs sampled at the previous rising edge.
// No backpressure: a new operation is accepted every cycle.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] ALUResult,
    output logic             ble,
    output logic             branchResult
);

    logic [WIDTH-1:0] alu_result_d, alu_result_q;
    logic             ble_d, ble_q;
    logic             branch_result_d, branch_result_q;
    logic [WIDTH-1:0] core_result;
    logic             core_ble;
    logic             core_eq;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (A),
        .b      (B),
        .op     (op),
        .result (core_result),
        .ble    (core_ble),
        .eq     (core_eq)
    );

    always_comb begin
        alu_result_d    = core_result;
        ble_d           = core_ble;
        branch_result_d = core_eq;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_result_q    <= '0;
            ble_q           <= 1'b0;
            branch_result_q <= 1'b0;
        end else begin
            alu_result_q    <= alu_result_d;
            ble_q           <= ble_d;
            branch_result_q <= branch_result_d;
        end
    end

    assign ALUResult    = alu_result_q;
    assign ble          = ble_q;
    assign branchResult = branch_result_q;

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: reset, arithmetic/logic/shift vectors, flags, latency, mid-stream reset.
module tb_alu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] A;
    logic [15:0] B;
    logic [2:0]  op;
    logic [15:0] ALUResult;
    logic        ble;
    logic        branchResult;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu #(.WIDTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .A            (A),
        .B            (B),
        .op           (op),
        .ALUResult    (ALUResult),
        .ble          (ble),
        .branchResult (branchResult)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [15:0] r, input logic l, input logic e);
        chk({tag, "_res"}, ALUResult, r);
        chk({tag, "_ble"}, {15'd0, ble}, {15'd0, l});
        chk({tag, "_eq"}, {15'd0, branchResult}, {15'd0, e});
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [2:0] o);
        A  = a;
        B  = b;
        op = o;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Signed <= via offset-binary: flipping the sign bit makes unsigned order match signed order.
    function automatic logic ref_ble(input logic [15:0] a, input logic [15:0] b);
        return (a ^ 16'h8000) <= (b ^ 16'h8000);
    endfunction

    initial begin
        logic [15:0] ra, rb;

        // Reset holds outputs at zero with no edge required.
        reset = 1'b1;
        drive(16'd5, 16'd3, OP_ADD);
        #2;
        chk3("reset_hold", 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk3("first_after_reset", 16'h0008, 1'b0, 1'b0);

        // ADD directed
        drive(16'h0005, 16'h0003, OP_ADD); tick();
        chk3("add_5_3", 16'h0008, 1'b0, 1'b0);
        drive(16'h7FFF, 16'h0001, OP_ADD); tick();
        chk3("add_wrap", 16'h8000, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            ra = 16'($urandom);
            rb = (i == 3) ? ra : 16'($urandom);
            drive(ra, rb, OP_ADD); tick();
            chk3("add_rand", ra + rb, ref_ble(ra, rb), ra == rb);
        end

        // SUB directed
        drive(16'h0004, 16'h0004, OP_SUB); tick();
        chk3("sub_equal", 16'h0000, 1'b1, 1'b1);
        drive(16'h8000, 16'h7FFF, OP_SUB); tick();
        chk3("sub_ovf", 16'h0001, 1'b1, 1'b0);
        drive(16'h8000, 16'h0001, OP_SUB); tick();
        chk3("sub_wrap", 16'h7FFF, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) begin
            ra = 16'($urandom);
            rb = (i == 5) ? ra : 16'($urandom);
            drive(ra, rb, OP_SUB); tick();
            chk3("sub_rand", ra - rb, ref_ble(ra, rb), ra == rb);
        end

        // Logic ops
        drive(16'hF0F0, 16'h0FF0, OP_AND); tick();
        chk3("and", 16'h00F0, 1'b1, 1'b0);
        drive(16'hF0F0, 16'h0FF0, OP_OR); tick();
        chk("or", ALUResult, 16'hFFF0);
        drive(16'hF0F0, 16'h0FF0, OP_XOR); tick();
        chk("xor", ALUResult, 16'hFF00);

        // Shifts, including zero shift and ignored upper B bits
        drive(16'h8001, 16'h0004, OP_SLL); tick();
        chk("sll_4", ALUResult, 16'h0010);
        drive(16'h8001, 16'h0004, OP_SRA); tick();
        chk("sra_4", ALUResult, 16'hF800);
        drive(16'h8001, 16'h0000, OP_SLL); tick();
        chk("sll_0", ALUResult, 16'h8001);
        drive(16'h8001, 16'hFFF0, OP_SRA); tick();
        chk("sra_hi_ignored", ALUResult, 16'h8001);
        drive(16'h0003, 16'h0011, OP_SLL); tick();
        chk("sll_hi_ignored", ALUResult, 16'h0006);
        drive(16'h4000, 16'h000F, OP_SRA); tick();
        chk("sra_pos_15", ALUResult, 16'h0000);

        drive(16'h0000, 16'h1234, OP_PASSB); tick();
        chk3("passb", 16'h1234, 1'b1, 1'b0);

        // Latency: new inputs must not reach outputs before the next edge.
        drive(16'h0001, 16'h0002, OP_ADD); tick();
        chk3("lat0", 16'h0003, 1'b1, 1'b0);
        drive(16'h00FF, 16'h0F0F, OP_XOR);
        #3;
        chk3("lat0_hold", 16'h0003, 1'b1, 1'b0);
        tick();
        chk3("lat1", 16'h0FF0, 1'b1, 1'b0);
        drive(16'h0010, 16'h0020, OP_SUB);
        #3;
        chk("lat1_hold", ALUResult, 16'h0FF0);
        tick();
        chk3("lat2", 16'hFFF0, 1'b1, 1'b0);

        // Reset asserted between edges clears immediately; recovery one edge after release.
        drive(16'h1111, 16'h2222, OP_OR); tick();
        chk3("pre_midreset", 16'h3333, 1'b1, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        chk3("midreset_clear", 16'h0000, 1'b0, 1'b0);
        tick();
        chk3("midreset_held", 16'h0000, 1'b0, 1'b0);
        #3;
        reset = 1'b0;
        #1;
        chk3("release_no_edge", 16'h0000, 1'b0, 1'b0);
        tick();
        chk3("after_release", 16'h3333, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
